// File: rtl/des_region_scheduler.sv
// des_region_scheduler: drives one des_block worker across a run of message
// regions, accumulating its counters, or streams test ciphertexts in test mode.
module des_region_scheduler #(
  parameter int unsigned CNT_W = 48,
  parameter int unsigned TOT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_start,
  input  logic             run_abort,
  input  logic             run_test,
  input  logic [15:0]      first_region,
  input  logic [15:0]      last_region,
  input  logic [15:0]      test_count,
  output logic             busy,
  output logic             run_done,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  output logic             res_valid,
  output logic [15:0]      res_region,
  output logic [CNT_W-1:0] res_count,
  output logic [63:0]      ct_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic             blk_start,
  output logic             blk_restart,
  output logic             blk_test_enabled,
  output logic             blk_test_advance,
  output logic [15:0]      blk_region_select,
  input  logic             blk_done,
  input  logic [CNT_W-1:0] blk_counter,
  input  logic             blk_test_data_valid,
  input  logic [63:0]      blk_ciphertext
);

  localparam int unsigned REG_W = 16;
  localparam int unsigned SUM_W = TOT_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESTART,
    S_START,
    S_WAIT,
    S_ACCUM,
    S_TRESTART,
    S_TSTART,
    S_TWAIT,
    S_TOUT,
    S_TADV,
    S_TSKIP,
    S_TEND,
    S_FINISHED
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               start_c;
  logic               abort_c;
  logic [REG_W-1:0]   cur_region_q;
  logic [REG_W-1:0]   cur_region_d;
  logic [REG_W-1:0]   last_region_q;
  logic [REG_W-1:0]   test_count_q;
  logic [REG_W-1:0]   test_cnt_q;
  logic [REG_W-1:0]   test_cnt_inc_c;
  logic [SUM_W-1:0]   sum_c;

  logic busy_d;
  logic run_done_d;
  logic res_valid_d;
  logic ct_valid_d;
  logic blk_start_d;
  logic blk_restart_d;
  logic blk_test_enabled_d;
  logic blk_test_advance_d;

  assign test_cnt_inc_c = test_cnt_q + REG_W'(1);
  assign sum_c          = SUM_W'(total) + SUM_W'(blk_counter);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks everything outside IDLE
  always_comb begin
    state_d      = state_q;
    cur_region_d = cur_region_q;
    start_c      = 1'b0;
    abort_c      = 1'b0;
    if (run_abort && (state_q != S_IDLE)) begin
      abort_c = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FINISHED: begin
          if (run_start) begin
            start_c      = 1'b1;
            cur_region_d = first_region;
            if (run_test) begin
              state_d = (test_count == '0) ? S_FINISHED : S_TRESTART;
            end else begin
              state_d = (first_region > last_region) ? S_FINISHED : S_RESTART;
            end
          end
        end
        S_RESTART: state_d = S_START;
        S_START:   state_d = S_WAIT;
        S_WAIT: begin
          if (blk_done) state_d = S_ACCUM;
        end
        S_ACCUM: begin
          // compare before incrementing so region FFFF never wraps
          if (cur_region_q == last_region_q) begin
            state_d = S_FINISHED;
          end else begin
            state_d      = S_RESTART;
            cur_region_d = cur_region_q + REG_W'(1);
          end
        end
        S_TRESTART: state_d = S_TSTART;
        S_TSTART:   state_d = S_TWAIT;
        S_TWAIT: begin
          if (blk_test_data_valid) state_d = S_TOUT;
        end
        S_TOUT: begin
          if (ct_ready) begin
            state_d = (test_cnt_inc_c == test_count_q) ? S_TEND : S_TADV;
          end
        end
        S_TADV:  state_d = S_TSKIP;
        S_TSKIP: state_d = S_TWAIT;
        S_TEND:  state_d = S_FINISHED;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every output comes from a flop
  always_comb begin
    busy_d             = 1'b0;
    run_done_d         = 1'b0;
    res_valid_d        = 1'b0;
    ct_valid_d         = 1'b0;
    blk_start_d        = 1'b0;
    blk_restart_d      = 1'b0;
    blk_test_enabled_d = 1'b0;
    blk_test_advance_d = 1'b0;
    busy_d             = !(state_d inside {S_IDLE, S_FINISHED});
    run_done_d         = (state_d == S_FINISHED);
    res_valid_d        = (state_d == S_ACCUM);
    ct_valid_d         = (state_d == S_TOUT);
    blk_start_d        = (state_d inside {S_START, S_TSTART});
    blk_restart_d      = abort_c || (state_d inside {S_RESTART, S_TRESTART, S_TEND});
    blk_test_enabled_d = (state_d inside {S_TRESTART, S_TSTART, S_TWAIT,
                                          S_TOUT, S_TADV, S_TSKIP});
    blk_test_advance_d = (state_d == S_TADV);
  end

  // Control output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy             <= 1'b0;
      run_done         <= 1'b0;
      res_valid        <= 1'b0;
      ct_valid         <= 1'b0;
      blk_start        <= 1'b0;
      blk_restart      <= 1'b0;
      blk_test_enabled <= 1'b0;
      blk_test_advance <= 1'b0;
    end else begin
      busy             <= busy_d;
      run_done         <= run_done_d;
      res_valid        <= res_valid_d;
      ct_valid         <= ct_valid_d;
      blk_start        <= blk_start_d;
      blk_restart      <= blk_restart_d;
      blk_test_enabled <= blk_test_enabled_d;
      blk_test_advance <= blk_test_advance_d;
    end
  end

  // Run parameters, accumulator, result capture and ciphertext holding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_region_q      <= '0;
      last_region_q     <= '0;
      test_count_q      <= '0;
      test_cnt_q        <= '0;
      total             <= '0;
      overflow          <= 1'b0;
      res_region        <= '0;
      res_count         <= '0;
      ct_data           <= '0;
      blk_region_select <= '0;
    end else begin
      cur_region_q <= cur_region_d;
      if (start_c) begin
        last_region_q <= last_region;
        test_count_q  <= test_count;
        test_cnt_q    <= '0;
        total         <= '0;
        overflow      <= 1'b0;
      end
      // accumulate on the edge that sees done so total and res_valid appear together
      if ((state_q == S_WAIT) && (state_d == S_ACCUM)) begin
        total      <= sum_c[TOT_W-1:0];
        overflow   <= overflow | sum_c[TOT_W];
        res_region <= cur_region_q;
        res_count  <= blk_counter;
      end
      if ((state_q == S_TOUT) && ct_ready && !abort_c) begin
        test_cnt_q <= test_cnt_inc_c;
      end
      if ((state_q == S_TWAIT) && (state_d == S_TOUT)) begin
        ct_data <= blk_ciphertext;
      end
      // region select only changes when a new region is restarted
      if (state_d == S_RESTART) begin
        blk_region_select <= cur_region_d;
      end
    end
  end

endmodule
